// File: rtl/usart_rx.sv
// usart_rx: 8E1 asynchronous serial receiver (start, 8 data LSB first,
// even parity, stop) with one-cycle valid strobe and per-frame error flags.
module usart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_sync;
  logic        w_rx_s;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_nxt;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic        r_par;
  logic        w_par_nxt;
  logic        r_armed;
  logic        w_armed_nxt;
  logic        w_load;
  logic [7:0]  r_data;
  logic        r_perr;
  logic        r_ferr;
  logic        r_valid;

  assign w_rx_s = r_sync[1];

  // armed needs a high line in IDLE, so a held break cannot retrigger
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_armed_nxt = r_armed;
    w_load      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rx_s) begin
          w_armed_nxt = 1'b1;
        end else if (r_armed) begin
          w_armed_nxt = 1'b0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt   = '0;
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = w_rx_s;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_PARITY;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt   = '0;
          w_par_nxt   = w_rx_s;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt   = '0;
          w_load      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_armed <= 1'b0;
      r_data  <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rx_i};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_armed <= w_armed_nxt;
      r_valid <= w_load;
      // results land with the strobe, during the DONE cycle
      if (w_load) begin
        r_data <= r_shift;
        r_perr <= ^{r_shift, r_par};
        r_ferr <= ~w_rx_s;
      end
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = (r_state != S_IDLE);

endmodule
